// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD engine among N requesters.
// Zero operands are answered locally; a watchdog aborts a stuck engine.
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic [N*W-1:0]       in1_bus_i,
    input  logic [N*W-1:0]       in2_bus_i,
    output logic [N-1:0]         gnt_o,
    output logic                 busy_o,
    output logic                 rsp_valid_o,
    output logic [$clog2(N)-1:0] rsp_id_o,
    output logic [W-1:0]         rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 eng_go_o,
    output logic [W-1:0]         eng_in1_o,
    output logic [W-1:0]         eng_in2_o,
    output logic                 eng_rst_o,
    input  logic                 eng_done_i,
    input  logic [W-1:0]         eng_out_i
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP, S_ABORT
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  id_q, id_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0]   data_q, data_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];
    logic           found;
    logic [IW-1:0]  pick, rr_idx;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign a_arr[g] = in1_bus_i[g*W +: W];
        assign b_arr[g] = in2_bus_i[g*W +: W];
    end

    // First set request after the last winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = IW'((int'(last_q) + k) % N);
            if (!found && req_i[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        gnt_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (found && !rst_i) begin
                    gnt_o[pick] = 1'b1;
                    last_d      = pick;
                    id_d        = pick;
                    opa_d       = a_arr[pick];
                    opb_d       = b_arr[pick];
                    // gcd(x,0) = x, and the engine would spin forever on it
                    if (a_arr[pick] == '0 || b_arr[pick] == '0) begin
                        data_d  = a_arr[pick] | b_arr[pick];
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done_i)
                    state_d = S_CAPTURE;
                else if (cnt_q == CW'(TIMEOUT - 1))
                    state_d = S_ABORT;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_CAPTURE: begin
                data_d  = eng_out_i;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_ABORT: begin
                data_d  = '0;
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= IW'(N - 1);
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign eng_go_o    = (state_q == S_ISSUE);
    assign eng_in1_o   = opa_q;
    assign eng_in2_o   = opb_q;
    assign eng_rst_o   = rst_i | (state_q == S_ABORT);
endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural engine, transaction-level reference model,
// directed scenarios followed by randomized request patterns.
module tb_gcd_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] in1_bus, in2_bus;
    logic [N-1:0]   gnt;
    logic           busy, rsp_valid, rsp_err, eng_go, eng_rst, eng_done;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data, eng_in1, eng_in2, eng_out;

    always #5 clk = ~clk;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .in1_bus_i(in1_bus), .in2_bus_i(in2_bus),
        .gnt_o(gnt), .busy_o(busy), .rsp_valid_o(rsp_valid),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .eng_go_o(eng_go), .eng_in1_o(eng_in1), .eng_in2_o(eng_in2),
        .eng_rst_o(eng_rst), .eng_done_i(eng_done), .eng_out_i(eng_out)
    );

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in1_bus[i*W +: W] = a_op[i];
            in2_bus[i*W +: W] = b_op[i];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Reference model: at most one job in flight, tracked by its expected event cycles
    bit           stall = 1'b0;
    bit           j_act = 1'b0;
    bit           j_err;
    int           j_id, j_g, j_go = -1, j_rsp = -1, j_abort = -1;
    logic [W-1:0] j_a, j_b, j_exp;
    int           last_m = N - 1;
    int           g_cnt [N];
    int           gq [$];
    bit           prev_rst = 1'b0;

    initial begin
        int pk;
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) g_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("eng_rst_during_rst", eng_rst, 1);
                chk("gnt_during_rst", gnt, 0);
                j_act    = 1'b0;
                last_m   = N - 1;
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    chk("rst_rsp_data", rsp_data, 0);
                    chk("rst_rsp_id", rsp_id, 0);
                    chk("rst_rsp_err", rsp_err, 0);
                    chk("rst_eng_in1", eng_in1, 0);
                    chk("rst_eng_in2", eng_in2, 0);
                    prev_rst = 1'b0;
                end
                eg = '0;
                pk = -1;
                if (!j_act) begin
                    pk = rr_pick(last_m, req);
                    if (pk >= 0) eg[pk] = 1'b1;
                end
                chk("gnt", gnt, eg);
                chk("busy", busy, j_act);
                chk("eng_go", eng_go, j_act && (j_go == cyc));
                if (j_act && eng_go) begin
                    chk("eng_in1", eng_in1, j_a);
                    chk("eng_in2", eng_in2, j_b);
                end
                if (j_act && eng_done) j_rsp = cyc + 2;
                chk("eng_rst", eng_rst, j_act && (j_abort == cyc));
                chk("rsp_valid", rsp_valid, j_act && (j_rsp == cyc));
                if (j_act && j_rsp == cyc) begin
                    chk("rsp_id", rsp_id, 64'(j_id));
                    chk("rsp_data", rsp_data, j_exp);
                    chk("rsp_err", rsp_err, j_err);
                    j_act = 1'b0;
                end else if (j_act && cyc > j_g + TO + 20) begin
                    chk("job_timeout", 0, 1);
                    j_act = 1'b0;
                end
                if (pk >= 0) begin
                    j_act = 1'b1;
                    j_id  = pk;
                    j_a   = a_op[pk];
                    j_b   = b_op[pk];
                    j_g   = cyc;
                    j_err = 1'b0;
                    j_exp = gcd_ref(j_a, j_b);
                    j_abort = -1;
                    if (j_a == 0 || j_b == 0) begin
                        j_go  = -1;
                        j_rsp = cyc + 1;
                    end else begin
                        j_go  = cyc + 1;
                        j_rsp = -1;
                        if (stall) begin
                            j_abort = j_go + TO + 1;
                            j_rsp   = j_go + TO + 2;
                            j_exp   = '0;
                            j_err   = 1'b1;
                        end
                    end
                    g_cnt[pk]++;
                    gq.push_back(pk);
                    last_m = pk;
                end
            end
        end
    end

    // Behavioural engine: random latency, done for one cycle, result valid the cycle after
    initial begin
        logic s_go, s_rst, e_busy;
        logic [W-1:0] s_a, s_b, e_res;
        int e_cnt;
        eng_done = 1'b0;
        eng_out  = '0;
        e_busy   = 1'b0;
        e_res    = '0;
        e_cnt    = 0;
        forever begin
            @(negedge clk);
            s_go = eng_go; s_rst = eng_rst; s_a = eng_in1; s_b = eng_in2;
            @(posedge clk);
            #1;
            if (s_rst) begin
                e_busy   = 1'b0;
                eng_done = 1'b0;
                eng_out  = '0;
            end else begin
                if (eng_done) begin
                    eng_done = 1'b0;
                    eng_out  = e_res;
                end
                if (s_go) begin
                    e_busy = 1'b1;
                    e_cnt  = $urandom_range(8, 1);
                    e_res  = gcd_ref(s_a, s_b);
                end else if (e_busy && !stall) begin
                    e_cnt--;
                    if (e_cnt == 0) begin
                        e_busy   = 1'b0;
                        eng_done = 1'b1;
                        eng_out  = ~e_res;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (j_act && k < 60) begin
            tick();
            k++;
        end
        chk("wait_idle_bound", j_act, 0);
    endtask

    task automatic wait_gnt(input int i);
        int c0 = g_cnt[i];
        int k  = 0;
        while (g_cnt[i] == c0 && k < 80) begin
            tick();
            k++;
        end
        chk("gnt_seen", (g_cnt[i] != c0), 1);
    endtask

    task automatic serve(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_op[i] = a;
        b_op[i] = b;
        req[i]  = 1'b1;
        wait_gnt(i);
        req[i]  = 1'b0;
        wait_idle();
        tick();
    endtask

    initial begin
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int k, c3, f, hold;
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single request from requester 1
        serve(1, 12, 18);
        chk("t1_gnt1_once", g_cnt[1], 1);

        // all requesters held: order 0,1,2,3,0
        pulse_rst();
        tick();
        gq.delete();
        a_op[0] = 48;  b_op[0] = 36;
        a_op[1] = 7;   b_op[1] = 5;
        a_op[2] = 100; b_op[2] = 75;
        a_op[3] = 9;   b_op[3] = 9;
        req = '1;
        k = 0;
        while (gq.size() < 5 && k < 300) begin tick(); k++; end
        req = '0;
        wait_idle();
        chk("t2_grant_count", (gq.size() >= 5), 1);
        if (gq.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t2_grant_order", 64'(gq[i]), 64'(exp_ord[i]));
        tick();

        // zero operands resolved locally
        serve(2, 0, 21);
        serve(2, 0, 0);

        // stuck engine, then a normal job
        stall = 1'b1;
        serve(1, 30, 12);
        stall = 1'b0;
        serve(1, 30, 12);

        // reset while waiting on the engine
        stall = 1'b1;
        a_op[2] = 77; b_op[2] = 21;
        req[2] = 1'b1;
        wait_gnt(2);
        req[2] = 1'b0;
        repeat (4) tick();
        req = '1;
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        wait_gnt(0);
        req = '0;
        chk("t5_winner_after_rst", 64'(gq[gq.size()-1]), 0);
        wait_idle();
        tick();

        // req[3] raised and withdrawn while busy
        c3 = g_cnt[3];
        a_op[0] = 48; b_op[0] = 36;
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        req[3] = 1'b1;
        tick();
        tick();
        req[3] = 1'b0;
        wait_idle();
        repeat (2) tick();
        chk("t6_no_gnt3", g_cnt[3], c3);

        // randomized request patterns
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                f = $urandom_range(40, 1);
                a_op[i] = ($urandom_range(5, 0) == 0) ? '0 : W'(f * $urandom_range(300, 1));
                b_op[i] = ($urandom_range(5, 0) == 0) ? '0 : W'(f * $urandom_range(300, 1));
            end
            stall = ($urandom_range(7, 0) == 0);
            req   = N'($urandom);
            hold  = $urandom_range(40, 1);
            repeat (hold) tick();
            req = '0;
            wait_idle();
            tick();
        end
        stall = 1'b0;

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
